// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the multi-cycle wide adder.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned CHUNK_DEFAULT = 64;

  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk < 2) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder with carry in and carry out.
module chunk_adder #(
  parameter int unsigned CHUNK = 64
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/seq_wide_adder.sv
// Multi-cycle W-bit adder: one CHUNK-bit slice per cycle through a registered carry.
// Optional subtract mode is enabled by defining WIDE_ADD_SUB_EN.
module seq_wide_adder
  import wide_add_pkg::*;
#(
  parameter int unsigned W     = 1024,
  parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned   NCHUNK = W / CHUNK;
  localparam int unsigned   IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST   = IW'(NCHUNK - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    b_ld;
  logic            c_ld;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic            c_sl;
  logic            accept;

  assign accept = (state_q == IDLE) && in_valid;

`ifdef WIDE_ADD_SUB_EN
  // Subtraction as a + ~b + 1; the forced carry replaces cin.
  always_comb begin
    b_ld = sub ? ~b : b;
    c_ld = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_ld = b;
    c_ld = cin;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)          state_d = RUN;
      RUN:     if (idx_q == LAST)     state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (s_sl),
    .cout (c_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_ld;
      carry_q <= c_ld;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (idx_q == IW'(i)) begin
          sum_q[i*CHUNK +: CHUNK] <= s_sl;
        end
      end
      carry_q <= c_sl;
      idx_q   <= idx_q + IW'(1);
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
// Directed bench for seq_wide_adder: 1024/64 and 16/4 instances.
module tb_seq_wide_adder;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [1023:0] a, b, sum;
`ifdef WIDE_ADD_SUB_EN
  logic          sub;
  logic          s_sub;
`endif
  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cin, s_cout;
  logic [15:0]   s_a, s_b, s_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_wide_adder #(.W(1024), .CHUNK(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef WIDE_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  seq_wide_adder #(.W(16), .CHUNK(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin),
`ifdef WIDE_ADD_SUB_EN
    .sub(s_sub),
`endif
    .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout)
  );

  typedef struct {
    logic [1023:0] a;
    logic [1023:0] b;
    logic          cin;
    logic [1023:0] s;
    logic          c;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
  } svec_t;

  function automatic vec_t mk(input logic [1023:0] va, input logic [1023:0] vb,
                              input logic vc, input logic [1023:0] vs, input logic vco);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.s = vs; v.c = vco;
    return v;
  endfunction

  function automatic svec_t mks(input logic [15:0] va, input logic [15:0] vb,
                                input logic vc, input logic [15:0] vs, input logic vco);
    svec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.s = vs; v.c = vco;
    return v;
  endfunction

  task automatic check_vec(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    int k;
    tests++;
    if (got !== exp) begin
      fails++;
      k = 0;
      for (int i = 15; i >= 0; i--) if (got[i*64 +: 64] !== exp[i*64 +: 64]) k = i;
      $display("FAIL %s: slice %0d got=%h required=%h", name, k, got[k*64 +: 64], exp[k*64 +: 64]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    check_vec(name, {1023'd0, got}, {1023'd0, exp});
  endtask

  // Returns once out_valid is seen (lat = edges after accept) or lat = -1 on timeout.
  task automatic run_op(input logic [1023:0] ta, input logic [1023:0] tb_, input logic tcin,
                        output int lat, output bit busy_bad);
    int g;
    busy_bad = 1'b0;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      lat = -1;
      return;
    end
    a = ta; b = tb_; cin = tcin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tcin;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic run_small(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                           output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!s_in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!s_in_ready) begin
      lat = -1;
      return;
    end
    s_a = ta; s_b = tb_; s_cin = tcin; s_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_a = ~ta; s_b = ~tb_;
    lat = 0;
    while (!s_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!s_out_valid) lat = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  vt[7];
    svec_t st[4];
    int    lat;
    bit    busy_bad;

    vt[0] = mk('1, 1024'd1, 1'b0, '0, 1'b1);
    vt[1] = mk(1024'd5, 1024'd3, 1'b1, 1024'd9, 1'b0);
    vt[2] = mk('0, '0, 1'b1, 1024'd1, 1'b0);
    vt[3] = mk('1, '1, 1'b1, '1, 1'b1);
    vt[4] = mk({960'd0, {64{1'b1}}}, 1024'd1, 1'b0, {959'd0, 1'b1, 64'd0}, 1'b0);
    vt[5] = mk({1'b1, 1023'd0}, {1'b1, 1023'd0}, 1'b0, '0, 1'b1);
    vt[6] = mk({960'd0, 1'b1, 63'd0}, {960'd0, 1'b1, 63'd0}, 1'b0, {959'd0, 1'b1, 64'd0}, 1'b0);

    st[0] = mks(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    st[1] = mks(16'h1234, 16'h0F0F, 1'b1, 16'h2144, 1'b0);
    st[2] = mks(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    st[3] = mks(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0);

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    sub = 1'b0; s_sub = 1'b0;
`endif

    #12;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_vec("rst_sum", sum, '0);
    check_bit("rst_cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_bit("post_rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, lat, busy_bad);
      check_vec($sformatf("v%0d_latency", i), lat, 16);
      check_vec($sformatf("v%0d_sum", i), sum, vt[i].s);
      check_bit($sformatf("v%0d_cout", i), cout, vt[i].c);
      check_bit($sformatf("v%0d_busy_in_ready", i), busy_bad, 1'b0);
      check_bit($sformatf("v%0d_done_in_ready", i), in_ready, 1'b0);
      @(posedge clk);
      #1;
      check_bit($sformatf("v%0d_idle_in_ready", i), in_ready, 1'b1);
      check_bit($sformatf("v%0d_idle_out_valid", i), out_valid, 1'b0);
    end

    // Backpressure in DONE, then a handshake coinciding with a new in_valid.
    out_ready = 1'b0;
    run_op(1024'h1234_5678, 1024'h1111_1111, 1'b0, lat, busy_bad);
    check_vec("bp_latency", lat, 16);
    @(negedge clk);
    a = 1024'd7; b = 1024'd8; cin = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_bit($sformatf("bp%0d_out_valid", c), out_valid, 1'b1);
      check_bit($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
      check_vec($sformatf("bp%0d_sum", c), sum, 1024'h2345_6789);
      check_bit($sformatf("bp%0d_cout", c), cout, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_bit("hs_out_valid", out_valid, 1'b0);
    check_bit("hs_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_bit("hs_accept_in_ready", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_vec("hs_latency", lat, 16);
    check_vec("hs_sum", sum, 1024'd15);
    check_bit("hs_cout", cout, 1'b0);

    // Reset while idx = 7.
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    a = '1; b = '0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check_vec("run_partial", {576'd0, sum[447:0]}, {576'd0, {448{1'b1}}});
    rst_n = 1'b0;
    #1;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_vec("midrst_sum", sum, '0);
    check_bit("midrst_cout", cout, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    check_bit("midrst_hold_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    check_bit("midrst_rel_in_ready", in_ready, 1'b1);
    run_op(1024'h1234, 1024'h1, 1'b0, lat, busy_bad);
    check_vec("after_rst_latency", lat, 16);
    check_vec("after_rst_sum", sum, 1024'h1235);
    check_bit("after_rst_cout", cout, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    sub = 1'b1;
    run_op('0, 1024'd1, 1'b0, lat, busy_bad);
    check_vec("sub0_latency", lat, 16);
    check_vec("sub0_sum", sum, '1);
    check_bit("sub0_cout", cout, 1'b0);
    run_op(1024'd10, 1024'd3, 1'b1, lat, busy_bad);
    check_vec("sub1_sum", sum, 1024'd7);
    check_bit("sub1_cout", cout, 1'b1);
    sub = 1'b0;
`endif

    for (int i = 0; i < 4; i++) begin
      run_small(st[i].a, st[i].b, st[i].cin, lat);
      check_vec($sformatf("s%0d_latency", i), lat, 4);
      check_vec($sformatf("s%0d_sum", i), {1008'd0, s_sum}, {1008'd0, st[i].s});
      check_bit($sformatf("s%0d_cout", i), s_cout, st[i].c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_wide_adder.md
# seq_wide_adder

Multi-cycle, parametrised wide-operand adder for the large-multiplication datapath. It adds two W-bit operands, from the final carry-propagate stage after Wallace reduction, by processing CHUNK-bit slices in successive cycles through a registered carry. This trades latency for a short critical path. Operands enter and results leave over valid/ready handshakes.

## Interface
Parameters:
- W, 1024, operand and result width; must be a multiple of CHUNK.
- CHUNK, 64, slice width added per cycle; NCHUNK = W/CHUNK, must be ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry in.
- sub  in  1  subtract select (present only with WIDE_ADD_SUB_EN).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  W  result.
- cout  out  1  carry out of bit W-1.

## Operation
- FSM states:
  - IDLE: in_ready=1.
    - Accept occurs on in_valid && in_ready.
    - On accept: latch a and b into registers, load the carry register with cin, clear the chunk index, and go to RUN.
  - RUN: each cycle, add slice idx of A and B plus the carry register.
    - Write the CHUNK-bit result into sum[idx*CHUNK +: CHUNK].
    - Update the carry register with the slice carry out, then increment idx.
    - After the slice idx = NCHUNK-1 is written, go to DONE.
  - DONE: out_valid=1.
    - sum and cout are held stable.
    - When out_ready=1, go to IDLE.
- in_ready is asserted only in IDLE; out_valid is asserted only in DONE.
- During RUN, sum may show partial contents and must not be sampled.
- cout equals the carry register after the last slice.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(W+1).
- in_valid is ignored outside IDLE; operand changes after the accept edge have no effect.
- A DONE handshake and a new in_valid in the same cycle do not overlap: the new operand is accepted in the following IDLE cycle at the earliest.
- Reset asserted at any point, mid-RUN included, aborts the operation:
  - state becomes IDLE;
  - sum=0, cout=0, out_valid=0, carry and idx are cleared;
  - in_ready=0 while rst_n is low, and 1 from the first cycle after release.

## Timing
- Accept edge T0: the first RUN cycle follows T0.
- NCHUNK RUN cycles follow.
- out_valid rises at edge T0+NCHUNK.
- Minimum accept-to-accept spacing is NCHUNK+2 cycles, given out_ready=1 at entry to DONE.
- Critical path: one CHUNK-bit ripple add plus the slice mux. It is independent of W.
- Reset values: out_valid=0, sum=0, cout=0, in_ready=0 while in reset.

## Configuration
- WIDE_ADD_SUB_EN defined:
  - sub port exists and is sampled at accept.
  - sub=1: B is stored bit-inverted, the carry register loads 1, and cin is ignored.
  - Result: sum = a − b mod 2^W, cout = 1 when no borrow (a ≥ b unsigned).
- WIDE_ADD_SUB_EN undefined: no sub port; add only, with no inversion logic.

## Structure
- Package wide_add_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - default CHUNK;
  - a function computing the index width, $clog2(NCHUNK).
- One sub-module, chunk_adder: combinational CHUNK-bit adder with carry in and carry out, instantiated once and time-shared across slices.

## Test plan
- W=1024, CHUNK=64:
  - Stimulus: a=all ones, b=1, cin=0.
  - Response: sum=0, cout=1; out_valid rises exactly 16 cycles after the accept edge (full carry ripple across slices).
- Stimulus: a=5, b=3, cin=1.
  - Response: sum=9, cout=0; in_ready=0 from accept until the cycle after the out handshake.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE.
  - Response: sum and cout stable, out_valid=1, in_ready=0 throughout; after the handshake, IDLE with in_ready=1 on the next cycle.
- Reset in RUN:
  - Stimulus: assert rst_n=0 while idx=7.
  - Response: out_valid=0, sum=0 immediately. After release, a+b with a=0x1234 and b=0x1 gives 0x1235, cout=0.
- WIDE_ADD_SUB_EN:
  - a=0, b=1, sub=1 → sum=all ones, cout=0.
  - a=10, b=3, sub=1, cin=1 → sum=7, cout=1 (cin ignored).
- W=16, CHUNK=4:
  - Stimulus: a=0xFFFF, b=0x0001, cin=0.
  - Response: sum=0, cout=1, out_valid 4 cycles after accept.
